sid_bus_if: RTL and testbench
=============================

Name: sid_bus_if

Overview:
Host-side register bus endpoint for the SID core. It samples an asynchronous 6502-style chip-select bus and turns each write cycle into a single-clock WR/ADDR/DATA strobe. That strobe feeds the voice, envelope and filter register decoders. It also answers host read cycles with the read-only registers ($19-$1C) and emulates the decaying data-bus latch for write-only addresses.

Parameters:
SYNC_STAGES, 2, flip-flops in the bus_cs_n synchroniser (>=2)
DECAY_CYCLES, 2048, clk cycles without a write before the bus latch reads back as 0 (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
bus_cs_n  in  1  host chip select, active low, asynchronous to clk
bus_rw  in  1  host direction: 1 = read, 0 = write; stable while bus_cs_n low
bus_addr  in  5  host register address; stable while bus_cs_n low
bus_data_i  in  8  host write data; stable while bus_cs_n low
bus_data_o  out  8  read data returned to host
bus_data_oe  out  1  read-data output enable
potx  in  8  POTX value ($19)
poty  in  8  POTY value ($1A)
osc3  in  8  voice-3 oscillator upper byte ($1B)
env3  in  8  voice-3 envelope ($1C)
WR  out  1  single-cycle register write strobe to SID decoders
ADDR  out  5  register address, valid when WR=1
DATA  out  8  register data, valid when WR=1

Behaviour:
- Reset, asynchronous with rst_n low: WR=0, ADDR=0, DATA=0, bus_data_o=0, bus_data_oe=0. Synchroniser flops preset to 1 (deasserted). FSM goes to IDLE. Bus latch = 0. Decay counter = 0.
- bus_cs_n passes through SYNC_STAGES flops giving cs_s. The falling edge of cs_s (prev 1, now 0) is the bus-cycle start, detected SYNC_STAGES cycles after the raw falling edge.
- bus_rw, bus_addr and bus_data_i are not synchronised. They are sampled only in the start-detect cycle. The host protocol guarantees they are stable by then.
- FSM states: IDLE, WRITE, READ, WAIT_REL.
- IDLE: on start with bus_rw=0, capture ADDR<=bus_addr and DATA<=bus_data_i, go to WRITE. On start with bus_rw=1, go to READ. Otherwise stay.
- WRITE: WR=1 for exactly this cycle. Latch<=DATA, decay counter<=DECAY_CYCLES. Go to WAIT_REL.
- READ: bus_data_o is registered from the address captured at the start:
  - $19 -> potx, $1A -> poty, $1B -> osc3, $1C -> env3.
  - All other addresses ($00-$18, $1D-$1F) -> bus latch.
  - Read values are snapshotted in this cycle and do not track later input changes.
  - bus_data_oe<=1. Go to WAIT_REL.
- WAIT_REL: hold outputs. When cs_s=1: bus_data_oe<=0, go to IDLE. bus_data_o keeps its last value.
- Write-to-read latency: WR high exactly SYNC_STAGES+1 cycles after the raw bus_cs_n fall. Read: bus_data_oe high SYNC_STAGES+1 cycles after the fall.
- WR is never asserted more than once per bus cycle, however long cs is held.
- Decay: the counter decrements every cycle while >0. On the cycle it reaches 0, latch<=0. A write reloads the counter and overrides a same-cycle decrement.
- A read of a write-only address returns the latch without reloading the counter. Reads never modify the latch.
- A cs pulse shorter than the synchroniser window may be missed; this is outside the host protocol and not an error.
- A new falling edge cannot occur in WRITE, READ or WAIT_REL, because cs must rise first. WAIT_REL always returns through IDLE.
- Reset mid-cycle: everything returns to reset values immediately and any pending WR is dropped. If cs is still low after reset release, the synchroniser's preset-1 state makes the low level look like a fresh edge. That cycle is accepted.
- Width rules: decay counter width is $clog2(DECAY_CYCLES+1). No arithmetic on data paths.

Decomposition:
- Shared sid package: register address constants ADDR_POTX=5'h19, ADDR_POTY=5'h1A, ADDR_OSC3=5'h1B, ADDR_ENV3=5'h1C, and the filter addresses $15-$17. Also the FSM state encoding.
- One sub-module: sync_fall, a parameterised SYNC_STAGES synchroniser with falling-edge detect, preset to 1 on reset.

Test Plan:
1. Write $16=8'hA5, cs held low 10 clk -> WR=1 for one cycle at +3 clk with ADDR=5'h16, DATA=8'hA5; no further WR until cs rises.
2. Set osc3=8'h3C, read $1B -> bus_data_oe=1 at +3 clk, bus_data_o=8'h3C. Change osc3 to 8'h00 mid-cycle -> bus_data_o stays 8'h3C. oe=0 SYNC_STAGES+1 clk after cs rises.
3. Write $04=8'h41, then read $04 after 100 clk -> 8'h41. Read again after DECAY_CYCLES+10 clk -> 8'h00.
4. Write $04=8'h41, then write $05=8'h77 at DECAY_CYCLES-5 clk -> the counter reloads. A read at DECAY_CYCLES+20 clk from the first write returns 8'h77.
5. Assert rst_n=0 one clk after a write-cycle cs fall -> WR never pulses, all outputs 0. Release with cs still low, rw=0 -> exactly one WR 3 clk after release.
6. Back-to-back write bursts to $15, $16, $17 with 4-clk cs-high gaps -> three WR pulses, in order, with the correct ADDR/DATA for each.

Source files
------------

// File: rtl/sid_bus_if_pkg.sv
// Shared SID register map and host-bus endpoint FSM encoding.
package sid_bus_if_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_FC_LO    = 5'h15;
    localparam logic [ADDR_W-1:0] ADDR_FC_HI    = 5'h16;
    localparam logic [ADDR_W-1:0] ADDR_RES_FILT = 5'h17;
    localparam logic [ADDR_W-1:0] ADDR_POTX     = 5'h19;
    localparam logic [ADDR_W-1:0] ADDR_POTY     = 5'h1A;
    localparam logic [ADDR_W-1:0] ADDR_OSC3     = 5'h1B;
    localparam logic [ADDR_W-1:0] ADDR_ENV3     = 5'h1C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT_REL
    } bus_state_e;

endpackage

// File: rtl/sid_bus_if_sync_fall.sv
// Multi-flop synchroniser for an active-low async strobe with falling-edge detect.
module sync_fall #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Preset high so a level held low across reset release reads as a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o   = sync_q[SYNC_STAGES-1];
    assign fall_o_c = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sid_bus_if.sv
// SID host register-bus endpoint: write strobe generation, read-only register
// readback and decaying data-bus latch emulation.
module sid_bus_if
    import sid_bus_if_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DECAY_CYCLES = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_cs_n,
    input  logic              bus_rw,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic [DATA_W-1:0] bus_data_o,
    output logic              bus_data_oe,
    input  logic [DATA_W-1:0] potx,
    input  logic [DATA_W-1:0] poty,
    input  logic [DATA_W-1:0] osc3,
    input  logic [DATA_W-1:0] env3,
    output logic              WR,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DATA
);

    localparam int unsigned CNT_W = $clog2(DECAY_CYCLES + 1);

    bus_state_e        state_q;
    logic              cs_s;
    logic              start_c;
    logic [DATA_W-1:0] latch_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rd_data_c;

    sync_fall #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_fall (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (bus_cs_n),
        .sync_o  (cs_s),
        .fall_o_c(start_c)
    );

    // Read-only registers, otherwise the decaying bus latch.
    always_comb begin
        rd_data_c = latch_q;
        case (bus_addr)
            ADDR_POTX: rd_data_c = potx;
            ADDR_POTY: rd_data_c = poty;
            ADDR_OSC3: rd_data_c = osc3;
            ADDR_ENV3: rd_data_c = env3;
            default:   rd_data_c = latch_q;
        endcase
    end

    // Bus-cycle FSM; WR and read data are set on the start-detect edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            WR          <= 1'b0;
            ADDR        <= '0;
            DATA        <= '0;
            bus_data_o  <= '0;
            bus_data_oe <= 1'b0;
        end else begin
            WR <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        if (!bus_rw) begin
                            ADDR    <= bus_addr;
                            DATA    <= bus_data_i;
                            WR      <= 1'b1;
                            state_q <= ST_WRITE;
                        end else begin
                            bus_data_o  <= rd_data_c;
                            bus_data_oe <= 1'b1;
                            state_q     <= ST_READ;
                        end
                    end
                end
                ST_WRITE:    state_q <= ST_WAIT_REL;
                ST_READ:     state_q <= ST_WAIT_REL;
                ST_WAIT_REL: begin
                    if (cs_s) begin
                        bus_data_oe <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

    // Bus latch: loaded by a write, cleared once the counter runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_q <= '0;
            cnt_q   <= '0;
        end else if (state_q == ST_WRITE) begin
            latch_q <= DATA;
            cnt_q   <= CNT_W'(DECAY_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                latch_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sid_bus_if.sv
// Scoreboard bench for sid_bus_if: expected writes/reads queued at stimulus time.
module tb_sid_bus_if;
    import sid_bus_if_pkg::*;

    localparam int unsigned SYNC_STAGES  = 2;
    localparam int unsigned DECAY_CYCLES = 2048;
    localparam int          LAT          = SYNC_STAGES + 1;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_exp_t;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } rd_exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bus_cs_n;
    logic       bus_rw;
    logic [4:0] bus_addr;
    logic [7:0] bus_data_i;
    logic [7:0] bus_data_o;
    logic       bus_data_oe;
    logic [7:0] potx, poty, osc3, env3;
    logic       WR;
    logic [4:0] ADDR;
    logic [7:0] DATA;

    int      cyc = 0;
    int      n_tests = 0;
    int      n_fail = 0;
    wr_exp_t wq[$];
    rd_exp_t rq[$];
    logic    oe_prev = 1'b0;

    sid_bus_if #(
        .SYNC_STAGES (SYNC_STAGES),
        .DECAY_CYCLES(DECAY_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_cs_n   (bus_cs_n),
        .bus_rw     (bus_rw),
        .bus_addr   (bus_addr),
        .bus_data_i (bus_data_i),
        .bus_data_o (bus_data_o),
        .bus_data_oe(bus_data_oe),
        .potx       (potx),
        .poty       (poty),
        .osc3       (osc3),
        .env3       (env3),
        .WR         (WR),
        .ADDR       (ADDR),
        .DATA       (DATA)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every WR pulse and every oe rise must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wq.size() != 0 && wq[0].cyc < cyc) begin
                chk("wr_missed", 32'(cyc), 32'(wq[0].cyc));
                wq.delete(0);
            end
            if (rq.size() != 0 && rq[0].cyc < cyc) begin
                chk("rd_missed", 32'(cyc), 32'(rq[0].cyc));
                rq.delete(0);
            end
            if (WR) begin
                if (wq.size() == 0) begin
                    chk("wr_unexp", 32'(WR), 32'(0));
                end else begin
                    wr_exp_t e;
                    e = wq.pop_front();
                    chk("wr_cyc", 32'(cyc), 32'(e.cyc));
                    chk("wr_addr", 32'(ADDR), 32'(e.addr));
                    chk("wr_data", 32'(DATA), 32'(e.data));
                end
            end
            if (bus_data_oe && !oe_prev) begin
                if (rq.size() == 0) begin
                    chk("rd_unexp", 32'(bus_data_oe), 32'(0));
                end else begin
                    rd_exp_t r;
                    r = rq.pop_front();
                    chk("rd_cyc", 32'(cyc), 32'(r.cyc));
                    chk("rd_data", 32'(bus_data_o), 32'(r.data));
                end
            end
        end
        oe_prev = bus_data_oe;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [7:0] d, input int hold,
                             input int gap, output int fall_cyc);
        bus_rw     = 1'b0;
        bus_addr   = a;
        bus_data_i = d;
        bus_cs_n   = 1'b0;
        fall_cyc   = cyc;
        wq.push_back('{addr: a, data: d, cyc: cyc + LAT});
        repeat (hold) tick();
        bus_cs_n = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic bus_read(input logic [4:0] a, input logic [7:0] exp, input int hold,
                            input int gap);
        bus_rw   = 1'b1;
        bus_addr = a;
        bus_cs_n = 1'b0;
        rq.push_back('{data: exp, cyc: cyc + LAT});
        repeat (hold) tick();
        bus_cs_n = 1'b1;
        repeat (gap) tick();
    endtask

    logic [4:0] filt_addr[3];
    logic [7:0] filt_data[3];

    initial begin
        int f0, fx, r;
        rst_n      = 1'b0;
        bus_cs_n   = 1'b1;
        bus_rw     = 1'b1;
        bus_addr   = '0;
        bus_data_i = '0;
        potx       = 8'h12;
        poty       = 8'h34;
        osc3       = 8'h00;
        env3       = 8'h9E;

        repeat (3) @(negedge clk);
        chk("rst_wr", 32'(WR), 32'(0));
        chk("rst_addr", 32'(ADDR), 32'(0));
        chk("rst_data", 32'(DATA), 32'(0));
        chk("rst_rdo", 32'(bus_data_o), 32'(0));
        chk("rst_oe", 32'(bus_data_oe), 32'(0));
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // 1: long write cycle gives a single WR pulse
        bus_write(ADDR_FC_HI, 8'hA5, 10, 6, f0);

        // 2: read snapshot of osc3 survives a later input change; oe release timing
        osc3     = 8'h3C;
        bus_rw   = 1'b1;
        bus_addr = ADDR_OSC3;
        bus_cs_n = 1'b0;
        rq.push_back('{data: 8'h3C, cyc: cyc + LAT});
        repeat (5) tick();
        osc3 = 8'h00;
        @(negedge clk);
        chk("rd_hold", 32'(bus_data_o), 32'(8'h3C));
        tick();
        repeat (2) tick();
        bus_cs_n = 1'b1;
        r = cyc;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        chk("oe_hold_cyc", 32'(cyc), 32'(r + SYNC_STAGES));
        chk("oe_hold", 32'(bus_data_oe), 32'(1));
        @(negedge clk);
        chk("oe_release", 32'(bus_data_oe), 32'(0));
        chk("rdo_keep", 32'(bus_data_o), 32'(8'h3C));
        tick();
        repeat (4) tick();

        // Other read-only registers and a write-only address (latch still A5)
        bus_read(ADDR_POTX, 8'h12, 4, 6);
        bus_read(ADDR_POTY, 8'h34, 4, 6);
        bus_read(ADDR_ENV3, 8'h9E, 4, 6);
        bus_read(5'h00, 8'hA5, 4, 6);

        // 3: latch reads back, then decays to zero
        bus_write(5'h04, 8'h41, 4, 6, f0);
        wait_to(f0 + 100);
        bus_read(5'h04, 8'h41, 4, 6);
        wait_to(f0 + DECAY_CYCLES + 10);
        bus_read(5'h04, 8'h00, 4, 6);

        // 4: a second write just before decay reloads the counter
        bus_write(5'h04, 8'h41, 4, 6, f0);
        wait_to(f0 + DECAY_CYCLES - 5);
        bus_write(5'h05, 8'h77, 4, 6, fx);
        wait_to(f0 + DECAY_CYCLES + 20);
        bus_read(5'h04, 8'h77, 4, 6);

        // 5: reset during a write cycle drops it; cs still low on release is a new cycle
        bus_rw     = 1'b0;
        bus_addr   = 5'h09;
        bus_data_i = 8'h5C;
        bus_cs_n   = 1'b0;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_wr", 32'(WR), 32'(0));
        chk("mid_rst_addr", 32'(ADDR), 32'(0));
        chk("mid_rst_data", 32'(DATA), 32'(0));
        chk("mid_rst_rdo", 32'(bus_data_o), 32'(0));
        chk("mid_rst_oe", 32'(bus_data_oe), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;
        wq.push_back('{addr: 5'h09, data: 8'h5C, cyc: cyc + LAT});
        repeat (8) tick();
        bus_cs_n = 1'b1;
        repeat (6) tick();

        // 6: back-to-back filter register writes
        filt_addr[0] = ADDR_FC_LO;    filt_data[0] = 8'h11;
        filt_addr[1] = ADDR_FC_HI;    filt_data[1] = 8'h22;
        filt_addr[2] = ADDR_RES_FILT; filt_data[2] = 8'hF3;
        for (int i = 0; i < 3; i++) begin
            bus_write(filt_addr[i], filt_data[i], 4, 4, fx);
        end

        repeat (10) tick();
        chk("wq_empty", 32'(wq.size()), 32'(0));
        chk("rq_empty", 32'(rq.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
